// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline sequencing controller for the five-stage CPU.
// Decides stage-register enables/flushes (stall, bubble, exception and eret
// squash) and owns the multiply/divide busy timer.
//
// Ports:
//   clk, reset (async, active-low)
//   D_hazard, D_mdu              D-stage hazard / MDU-class instruction
//   E_mdu_start, E_mdu_div       E-stage MDU start request and div qualifier
//   Req, M_eret                  exception accepted / eret in M
//   F_en..W_en                   stage-register enables
//   D_flush, E_flush, M_flush    synchronous clears
//   mdu_start, mdu_busy          qualified MDU start / MDU occupied
//   mdu_state                    0 IDLE, 1 BUSY_MUL, 2 BUSY_DIV
//   stall_cnt, flush_cnt         statistics (only with PIPE_CTRL_STAT_EN)
//
// Build option: define PIPE_CTRL_STAT_EN to add the statistics counters.
//
// state    | meaning
// ---------+-----------------------------------------------
// IDLE     | MDU free, a start in E may be accepted
// BUSY_MUL | mult/multu in flight, cnt counting down
// BUSY_DIV | div/divu in flight, cnt counting down

module pipe_ctrl #(
    parameter int unsigned MULT_CYC = 5,
    parameter int unsigned DIV_CYC  = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       D_hazard,
    input  logic       D_mdu,
    input  logic       E_mdu_start,
    input  logic       E_mdu_div,
    input  logic       Req,
    input  logic       M_eret,
    output logic       F_en,
    output logic       D_en,
    output logic       E_en,
    output logic       M_en,
    output logic       W_en,
    output logic       D_flush,
    output logic       E_flush,
    output logic       M_flush,
    output logic       mdu_start,
    output logic       mdu_busy,
    output logic [1:0] mdu_state
`ifdef PIPE_CTRL_STAT_EN
    ,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        BUSY_MUL = 2'd1,
        BUSY_DIV = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       stall;
    logic       squash;

    // Squash (Req or eret) cancels a start in E; reset forces the start low.
    assign squash    = Req | M_eret;
    assign mdu_start = reset & E_mdu_start & ~squash & (state_q == IDLE);
    assign mdu_busy  = mdu_start | (cnt_q != 4'd0);
    assign stall     = D_hazard | (D_mdu & mdu_busy);
    assign mdu_state = state_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Busy states keep counting regardless of Req/eret: the operation
    // belongs to an older, already committed instruction.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (mdu_start) begin
                    if (E_mdu_div) begin
                        state_d = BUSY_DIV;
                        cnt_d   = 4'(DIV_CYC);
                    end else begin
                        state_d = BUSY_MUL;
                        cnt_d   = 4'(MULT_CYC);
                    end
                end
            end
            BUSY_MUL, BUSY_DIV: begin
                if (cnt_q <= 4'd1) begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_comb begin
        F_en    = 1'b1;
        D_en    = 1'b1;
        E_en    = 1'b1;
        M_en    = 1'b1;
        W_en    = 1'b1;
        D_flush = 1'b0;
        E_flush = 1'b0;
        M_flush = 1'b0;
        if (reset) begin
            if (squash) begin
                D_flush = 1'b1;
                E_flush = 1'b1;
                M_flush = 1'b1;
            end else if (stall) begin
                // Hold F/D, inject a bubble into D/E.
                F_en    = 1'b0;
                D_en    = 1'b0;
                E_flush = 1'b1;
            end
        end
    end

`ifdef PIPE_CTRL_STAT_EN
    logic [31:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            if (stall && !squash) stall_cnt_q <= stall_cnt_q + 32'd1;
            if (squash)           flush_cnt_q <= flush_cnt_q + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
module tb_pipe_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       D_hazard, D_mdu, E_mdu_start, E_mdu_div, Req, M_eret;
    logic       F_en, D_en, E_en, M_en, W_en;
    logic       D_flush, E_flush, M_flush;
    logic       mdu_start, mdu_busy;
    logic [1:0] mdu_state;
`ifdef PIPE_CTRL_STAT_EN
    logic [31:0] stall_cnt, flush_cnt;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    pipe_ctrl #(.MULT_CYC(5), .DIV_CYC(10)) dut (
        .clk         (clk),
        .reset       (reset),
        .D_hazard    (D_hazard),
        .D_mdu       (D_mdu),
        .E_mdu_start (E_mdu_start),
        .E_mdu_div   (E_mdu_div),
        .Req         (Req),
        .M_eret      (M_eret),
        .F_en        (F_en),
        .D_en        (D_en),
        .E_en        (E_en),
        .M_en        (M_en),
        .W_en        (W_en),
        .D_flush     (D_flush),
        .E_flush     (E_flush),
        .M_flush     (M_flush),
        .mdu_start   (mdu_start),
        .mdu_busy    (mdu_busy),
        .mdu_state   (mdu_state)
`ifdef PIPE_CTRL_STAT_EN
        ,
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs are changed here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Packed enables {F,D,E,M,W} and flushes {D,E,M}.
    function automatic logic [4:0] ens();
        return {F_en, D_en, E_en, M_en, W_en};
    endfunction
    function automatic logic [2:0] fls();
        return {D_flush, E_flush, M_flush};
    endfunction

    initial begin
        reset = 1'b0; D_hazard = 1'b1; D_mdu = 1'b0; E_mdu_start = 1'b1;
        E_mdu_div = 1'b0; Req = 1'b0; M_eret = 1'b0;
        #2;
        chk("rst_ens",   32'(ens()), 32'h1F);
        chk("rst_fls",   32'(fls()), 32'h0);
        chk("rst_state", 32'(mdu_state), 32'd0);
        chk("rst_start", 32'(mdu_start), 32'd0);
        chk("rst_busy",  32'(mdu_busy), 32'd0);
        tick(); tick();
        E_mdu_start = 1'b0;
        reset = 1'b1;
        #1;
        chk("hz_ens", 32'(ens()), 32'b00111);
        chk("hz_fls", 32'(fls()), 32'b010);

        // Mult with a dependent mfhi in D
        tick();
        D_hazard = 1'b0; D_mdu = 1'b1; E_mdu_start = 1'b1; E_mdu_div = 1'b0;
        #1;
        chk("mul_t_start", 32'(mdu_start), 32'd1);
        chk("mul_t_busy",  32'(mdu_busy), 32'd1);
        chk("mul_t_den",   32'(D_en), 32'd0);
        chk("mul_t_state", 32'(mdu_state), 32'd0);
        tick();
        E_mdu_start = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            #1;
            chk($sformatf("mul_busy_%0d", i),  32'(mdu_busy), 32'd1);
            chk($sformatf("mul_den_%0d", i),   32'(D_en), 32'd0);
            chk($sformatf("mul_state_%0d", i), 32'(mdu_state), 32'd1);
            chk($sformatf("mul_cnt_%0d", i),   32'(dut.cnt_q), 32'(6 - i));
            tick();
        end
        #1;
        chk("mul_end_busy",  32'(mdu_busy), 32'd0);
        chk("mul_end_den",   32'(D_en), 32'd1);
        chk("mul_end_state", 32'(mdu_state), 32'd0);

        // Div with dependent D_mdu: stall 11 cycles
        tick();
        E_mdu_start = 1'b1; E_mdu_div = 1'b1;
        #1;
        chk("div_t_den", 32'(D_en), 32'd0);
        tick();
        E_mdu_start = 1'b0; E_mdu_div = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            #1;
            chk($sformatf("div_den_%0d", i),   32'(D_en), 32'd0);
            chk($sformatf("div_state_%0d", i), 32'(mdu_state), 32'd2);
            tick();
        end
        #1;
        chk("div_end_den",   32'(D_en), 32'd1);
        chk("div_end_state", 32'(mdu_state), 32'd0);
        chk("div_end_busy",  32'(mdu_busy), 32'd0);
        D_mdu = 1'b0;

        // Start in E cancelled by Req (with a hazard pending: no stall)
        tick();
        E_mdu_start = 1'b1; Req = 1'b1; D_hazard = 1'b1;
        #1;
        chk("req_start", 32'(mdu_start), 32'd0);
        chk("req_fls",   32'(fls()), 32'b111);
        chk("req_ens",   32'(ens()), 32'h1F);
        tick();
        E_mdu_start = 1'b0; Req = 1'b0; D_hazard = 1'b0;
        #1;
        chk("req_state", 32'(mdu_state), 32'd0);
        chk("req_busy",  32'(mdu_busy), 32'd0);

        // Start in E cancelled by eret; Req+eret together behaves as Req
        E_mdu_start = 1'b1; M_eret = 1'b1;
        #1;
        chk("eret_start", 32'(mdu_start), 32'd0);
        Req = 1'b1;
        #1;
        chk("reqeret_fls", 32'(fls()), 32'b111);
        tick();
        E_mdu_start = 1'b0; M_eret = 1'b0; Req = 1'b0;
        #1;
        chk("eret_state", 32'(mdu_state), 32'd0);

        // Mult counting, Req arrives at cnt=3: count continues
        tick();
        E_mdu_start = 1'b1;
        tick();
        E_mdu_start = 1'b0;
        tick(); tick();
        Req = 1'b1; D_mdu = 1'b1;
        #1;
        chk("mreq_cnt3",  32'(dut.cnt_q), 32'd3);
        chk("mreq_fls",   32'(fls()), 32'b111);
        chk("mreq_ens",   32'(ens()), 32'h1F);
        chk("mreq_state", 32'(mdu_state), 32'd1);
        tick();
        Req = 1'b0; D_mdu = 1'b0;
        #1;
        chk("mreq_cnt2", 32'(dut.cnt_q), 32'd2);
        tick();
        #1;
        chk("mreq_cnt1", 32'(dut.cnt_q), 32'd1);
        tick();
        #1;
        chk("mreq_cnt0",  32'(dut.cnt_q), 32'd0);
        chk("mreq_idle",  32'(mdu_state), 32'd0);

        // Same with eret plus hazard
        E_mdu_start = 1'b1;
        tick();
        E_mdu_start = 1'b0;
        tick(); tick();
        M_eret = 1'b1; D_hazard = 1'b1;
        #1;
        chk("meret_cnt3", 32'(dut.cnt_q), 32'd3);
        chk("meret_fls",  32'(fls()), 32'b111);
        chk("meret_ens",  32'(ens()), 32'h1F);
        tick();
        M_eret = 1'b0; D_hazard = 1'b0;
        #1;
        chk("meret_cnt2", 32'(dut.cnt_q), 32'd2);
        tick();
        #1;
        chk("meret_cnt1", 32'(dut.cnt_q), 32'd1);
        tick();
        #1;
        chk("meret_cnt0", 32'(dut.cnt_q), 32'd0);

        // Reset mid-div abandons the operation
        E_mdu_start = 1'b1; E_mdu_div = 1'b1;
        tick();
        E_mdu_start = 1'b0; E_mdu_div = 1'b0;
        tick(); tick();
        chk("rmid_state_pre", 32'(mdu_state), 32'd2);
        reset = 1'b0;
        #1;
        chk("rmid_state", 32'(mdu_state), 32'd0);
        chk("rmid_busy",  32'(mdu_busy), 32'd0);
        tick();
        reset = 1'b1;
        tick();
        #1;
        chk("rmid_after", 32'(mdu_state), 32'd0);
        chk("rmid_cnt",   32'(dut.cnt_q), 32'd0);

`ifdef PIPE_CTRL_STAT_EN
        reset = 1'b0;
        #1;
        reset = 1'b1;
        D_hazard = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        D_hazard = 1'b0; Req = 1'b1;
        tick(); tick();
        Req = 1'b0;
        tick();
        chk("stat_stall", stall_cnt, 32'd7);
        chk("stat_flush", flush_cnt, 32'd2);
        reset = 1'b0;
        #1;
        chk("stat_rst_stall", stall_cnt, 32'd0);
        chk("stat_rst_flush", flush_cnt, 32'd0);
        reset = 1'b1;
`endif

        tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
